cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 32 +++
 rtl/fill_word_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 137 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and field positions for the cache block fill controller.
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StTagWr = 2'd2
    } fill_state_e;

    localparam int unsigned AddrW     = 16;
    localparam int unsigned TagLsb    = 10;
    localparam int unsigned TagW      = 6;
    localparam int unsigned IndexLsb  = 4;
    localparam int unsigned IndexW    = 6;
    localparam int unsigned OffsetLsb = 1;
    localparam int unsigned OffsetW   = 3;

    localparam int unsigned MetaValid  = 7;
    localparam int unsigned MetaLru    = 6;
    localparam int unsigned MetaTagMsb = 5;
    localparam int unsigned MetaTagLsb = 0;

    function automatic logic [7:0] build_meta(input logic [TagW-1:0] tag);
        logic [7:0] meta;
        meta                         = '0;
        meta[MetaValid]              = 1'b1;
        meta[MetaLru]                = 1'b0;
        meta[MetaTagMsb:MetaTagLsb]  = tag;
        return meta;
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// 3-bit word offset counter with parallel load; wraps 7->0 on increment.
module fill_word_counter
    import cache_fill_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [OffsetW-1:0] i_load_val,
    input  logic               i_inc,
    output logic [OffsetW-1:0] o_offset
);

    logic [OffsetW-1:0] r_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset <= '0;
        end else if (i_load) begin
            r_offset <= i_load_val;
        end else if (i_inc) begin
            r_offset <= r_offset + OffsetW'(1);
        end
    end

    assign o_offset = r_offset;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block fill controller: requests WORDS words, writes them, then writes metadata.
// Optional critical-word-first ordering via CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [15:0]       miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [15:0]       memory_address,
    output logic              write_data_array,
    output logic [2:0]        data_word_sel,
    output logic [SETS-1:0]   data_set_enable,
    output logic              meta_write,
    output logic [SETS-1:0]   meta_block_enable,
    output logic [7:0]        meta_data
);

    localparam int unsigned CntW = $clog2(WORDS + 1);

    fill_state_e        r_state;
    fill_state_e        w_state_next;
    logic [TagW-1:0]    r_tag;
    logic [IndexW-1:0]  r_index;
    logic [CntW-1:0]    r_req_cnt;
    logic [CntW-1:0]    r_rcv_cnt;
    logic [OffsetW-1:0] w_req_off;
    logic [OffsetW-1:0] w_rcv_off;
    logic [OffsetW-1:0] w_start_off;
    logic               w_load;
    logic               w_req_fire;
    logic               w_rcv_fire;
    logic               w_rcv_last;
    logic [SETS-1:0]    w_set_onehot;
    logic               w_unused_addr;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign w_start_off = miss_address[OffsetLsb +: OffsetW];
`else
    assign w_start_off = '0;
`endif

    assign w_unused_addr = ^miss_address[3:0];

    assign w_load     = (r_state == StIdle) && miss_detected;
    assign w_req_fire = (r_state == StFill) && (r_req_cnt < CntW'(WORDS));
    assign w_rcv_fire = (r_state == StFill) && memory_data_valid;
    assign w_rcv_last = w_rcv_fire && (r_rcv_cnt == CntW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_tag     <= '0;
            r_index   <= '0;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_tag     <= miss_address[TagLsb +: TagW];
                r_index   <= miss_address[IndexLsb +: IndexW];
                r_req_cnt <= '0;
                r_rcv_cnt <= '0;
            end else begin
                if (w_req_fire) r_req_cnt <= r_req_cnt + CntW'(1);
                if (w_rcv_fire) r_rcv_cnt <= r_rcv_cnt + CntW'(1);
            end
        end
    end

    fill_word_counter u_req_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_start_off),
        .i_inc      (w_req_fire),
        .o_offset   (w_req_off)
    );

    fill_word_counter u_rcv_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_start_off),
        .i_inc      (w_rcv_fire),
        .o_offset   (w_rcv_off)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (miss_detected) w_state_next = StFill;
            StFill:  if (w_rcv_last) w_state_next = StTagWr;
            StTagWr: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_set_onehot = {{(SETS - 1){1'b0}}, 1'b1} << r_index;

    always_comb begin
        fsm_busy          = 1'b0;
        mem_read_en       = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        data_word_sel     = '0;
        data_set_enable   = '0;
        meta_write        = 1'b0;
        meta_block_enable = '0;
        meta_data         = '0;
        if (r_state != StIdle) begin
            fsm_busy          = 1'b1;
            data_set_enable   = w_set_onehot;
            meta_block_enable = w_set_onehot;
        end
        if (w_req_fire) begin
            mem_read_en    = 1'b1;
            memory_address = {r_tag, r_index, w_req_off, 1'b0};
        end
        if (w_rcv_fire) begin
            write_data_array = 1'b1;
            data_word_sel    = w_rcv_off;
        end
        // Valid bit lands only after every data word is in the array.
        if (r_state == StTagWr) begin
            meta_write = 1'b1;
            meta_data  = build_meta(r_tag);
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm with a fixed-latency memory responder.
module tb_cache_fill_fsm;

    localparam int SETS  = 64;
    localparam int WORDS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            miss_detected;
    logic [15:0]     miss_address;
    logic            memory_data_valid;
    logic            fsm_busy;
    logic            mem_read_en;
    logic [15:0]     memory_address;
    logic            write_data_array;
    logic [2:0]      data_word_sel;
    logic [SETS-1:0] data_set_enable;
    logic            meta_write;
    logic [SETS-1:0] meta_block_enable;
    logic [7:0]      meta_data;

    logic            model_en;
    logic            force_valid;
    logic [3:0]      pipe;

    int n_checks = 0;
    int n_errors = 0;

    cache_fill_fsm #(
        .SETS  (SETS),
        .WORDS (WORDS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_sel     (data_word_sel),
        .data_set_enable   (data_set_enable),
        .meta_write        (meta_write),
        .meta_block_enable (meta_block_enable),
        .meta_data         (meta_data)
    );

    always #5 clk = ~clk;

    // Memory returns each requested word 4 cycles after the request, in order.
    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[2:0], mem_read_en & model_en};
    end
    assign memory_data_valid = force_valid | (model_en & pipe[3]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic rd, input logic [15:0] addr,
                               input logic wr, input logic [2:0] sel, input logic busy,
                               input logic [63:0] en, input logic mw, input logic [7:0] md);
        chk({tag, " mem_read_en"}, 64'(mem_read_en), 64'(rd));
        chk({tag, " memory_address"}, 64'(memory_address), 64'(addr));
        chk({tag, " write_data_array"}, 64'(write_data_array), 64'(wr));
        chk({tag, " data_word_sel"}, 64'(data_word_sel), 64'(sel));
        chk({tag, " fsm_busy"}, 64'(fsm_busy), 64'(busy));
        chk({tag, " data_set_enable"}, data_set_enable, en);
        chk({tag, " meta_block_enable"}, meta_block_enable, en);
        chk({tag, " meta_write"}, 64'(meta_write), 64'(mw));
        chk({tag, " meta_data"}, 64'(meta_data), 64'(md));
    endtask

    // Cycle 0 is the IDLE cycle presenting the miss; cycle 13 is TAG_WR.
    task automatic run_fill(input string name, input logic [15:0] a, input int inject);
        logic [5:0]  tag;
        logic [5:0]  idx;
        logic [2:0]  st;
        logic [2:0]  off;
        logic        rd;
        logic        wr;
        logic        busy;
        logic [15:0] addr;
        logic [2:0]  sel;
        int          busy_cnt;
        tag = a[15:10];
        idx = a[9:4];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        st = a[3:1];
`else
        st = 3'd0;
`endif
        busy_cnt = 0;
        for (int c = 0; c <= 13; c++) begin
            miss_detected = (c == 0) || (c == inject);
            miss_address  = (c == 0) ? a : 16'hFFFE;
            #1;
            rd   = (c >= 1) && (c <= 8);
            off  = st + 3'(c - 1);
            addr = rd ? {tag, idx, off, 1'b0} : 16'h0;
            wr   = (c >= 5) && (c <= 12);
            sel  = wr ? st + 3'(c - 5) : 3'd0;
            busy = (c >= 1);
            if (fsm_busy) busy_cnt++;
            check_cycle($sformatf("%s c%0d", name, c), rd, addr, wr, sel, busy,
                        busy ? (64'h1 << idx) : 64'h0, c == 13,
                        (c == 13) ? {2'b10, tag} : 8'h00);
            tick();
        end
        miss_detected = 1'b0;
        chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd13);
    endtask

    initial begin
        int wr_cnt;
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        force_valid   = 1'b0;
        model_en      = 1'b0;
        tick();
        tick();
        check_cycle("reset", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);
        rst = 1'b0;
        tick();

        // memory_data_valid in IDLE is ignored
        force_valid = 1'b1;
        #1;
        check_cycle("idle_valid", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);
        tick();
        force_valid = 1'b0;
        #1;
        check_cycle("idle_after_valid", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);
        tick();

        model_en = 1'b1;
        // Explicit hand values for the first and last requests of a 0x1234 miss
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        tick();
        miss_detected = 1'b0;
        #1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        chk("first_req_addr", 64'(memory_address), 64'h1234);
`else
        chk("first_req_addr", 64'(memory_address), 64'h1230);
`endif
        for (int i = 0; i < 7; i++) tick();
        #1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        chk("last_req_addr", 64'(memory_address), 64'h1232);
`else
        chk("last_req_addr", 64'(memory_address), 64'h123E);
`endif
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("tagwr_meta_write", 64'(meta_write), 64'd1);
        chk("tagwr_meta_data", 64'(meta_data), 64'h84);
        chk("tagwr_block_bit35", meta_block_enable, 64'h0000_0008_0000_0000);
        tick();
        tick();

        run_fill("miss_1234", 16'h1234, -1);
        tick();

        run_fill("mid_fill_miss", 16'h1234, 3);
        #1;
        check_cycle("after_mid_fill", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);
        tick();

        // Abort after three returned words
        wr_cnt = 0;
        for (int c = 0; c <= 7; c++) begin
            miss_detected = (c == 0);
            miss_address  = 16'h1234;
            #1;
            if (write_data_array) wr_cnt++;
            tick();
        end
        miss_detected = 1'b0;
        chk("abort_writes_before_rst", 64'(wr_cnt), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_cycle("abort_after_rst", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("abort_no_meta c%0d", c), 64'(meta_write), 64'd0);
            chk($sformatf("abort_idle_busy c%0d", c), 64'(fsm_busy), 64'd0);
        end

        // Back-to-back fills: second miss in the IDLE cycle right after TAG_WR
        run_fill("b2b_fc00", 16'hFC00, -1);
        run_fill("b2b_0010", 16'h0010, -1);
        #1;
        check_cycle("b2b_end", 0, 16'h0, 0, 3'd0, 0, 64'h0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
